// File: rtl/hex_entry_if.sv
// Button/preset inputs and display/commit outputs of the hex entry block.
interface hex_entry_if;
   logic       btn_inc;
   logic       btn_dec;
   logic       btn_sel;
   logic       btn_ok;
   logic       load_en;
   logic [7:0] load_data;
   logic [7:0] edit_value;
   logic       digit_sel;
   logic [7:0] data_out;
   logic       data_valid;

   modport master (
      output btn_inc, btn_dec, btn_sel, btn_ok, load_en, load_data,
      input  edit_value, digit_sel, data_out, data_valid
   );

   modport slave (
      input  btn_inc, btn_dec, btn_sel, btn_ok, load_en, load_data,
      output edit_value, digit_sel, data_out, data_valid
   );
endinterface

// File: rtl/hex_entry.sv
// Two-digit hex value entry: four debounced buttons edit an 8-bit buffer
// nibble by nibble, OK commits it to data_out with a one-cycle valid pulse.

// Per-button synchronizer, debouncer and rising-edge event pulse.
module hex_entry_db #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_evt
);
   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [1:0]  r_sync;
   logic        r_lvl;
   logic        r_lvl_d;
   logic        r_evt;
   logic [15:0] r_cnt;

   // Two-flop synchronizer for the raw asynchronous button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b00;
      else        r_sync <= {r_sync[0], i_btn};
   end

   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lvl <= 1'b0;
         r_cnt <= '0;
      end else if (r_sync[1] != r_lvl) begin
         if (r_cnt == CNT_LAST) begin
            r_lvl <= ~r_lvl;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // One-cycle event the cycle after the debounced level rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lvl_d <= 1'b0;
         r_evt   <= 1'b0;
      end else begin
         r_lvl_d <= r_lvl;
         r_evt   <= r_lvl & ~r_lvl_d;
      end
   end

   assign o_evt = r_evt;
endmodule

module hex_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   hex_entry_if.slave     bus
);
   typedef enum logic [1:0] {EDIT_HI, EDIT_LO, COMMIT} state_t;

   // Event order in the vector: 0 inc, 1 dec, 2 sel, 3 ok.
   logic [3:0] w_btn;
   logic [3:0] w_evt;
   logic [3:0] w_nib;
   logic [3:0] w_nib_nx;
   logic [7:0] w_edit_nx;

   state_t     r_state;
   logic [7:0] r_edit;
   logic [7:0] r_data_out;
   logic       r_data_valid;
   logic       r_digit_sel;

   assign w_btn = {bus.btn_ok, bus.btn_sel, bus.btn_dec, bus.btn_inc};

   for (genvar g = 0; g < 4; g++) begin : g_db
      hex_entry_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .i_btn (w_btn[g]),
         .o_evt (w_evt[g])
      );
   end

   // Selected nibble stepped up or down; the other nibble is carried through untouched.
   always_comb begin
      w_nib     = r_digit_sel ? r_edit[7:4] : r_edit[3:0];
      w_nib_nx  = w_evt[0] ? (w_nib + 4'd1) : (w_nib - 4'd1);
      w_edit_nx = r_digit_sel ? {w_nib_nx, r_edit[3:0]} : {r_edit[7:4], w_nib_nx};
   end

   // Edit FSM. The commit is latched on the edge entering COMMIT so data_out
   // and data_valid are visible for exactly the COMMIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= EDIT_HI;
         r_edit       <= 8'h00;
         r_data_out   <= 8'h00;
         r_data_valid <= 1'b0;
         r_digit_sel  <= 1'b1;
      end else begin
         r_data_valid <= 1'b0;
         if (bus.load_en) begin
            r_edit      <= bus.load_data;
            r_state     <= EDIT_HI;
            r_digit_sel <= 1'b1;
         end else begin
            case (r_state)
               COMMIT: begin
                  r_state     <= EDIT_HI;
                  r_digit_sel <= 1'b1;
               end
               default: begin
                  if (w_evt[3]) begin
                     r_state      <= COMMIT;
                     r_data_out   <= r_edit;
                     r_data_valid <= 1'b1;
                     r_digit_sel  <= 1'b1;
                  end else if (w_evt[2]) begin
                     r_state     <= (r_state == EDIT_HI) ? EDIT_LO : EDIT_HI;
                     r_digit_sel <= (r_state != EDIT_HI);
                  end else if (w_evt[0] ^ w_evt[1]) begin
                     r_edit <= w_edit_nx;
                  end
               end
            endcase
         end
      end
   end

   assign bus.edit_value = r_edit;
   assign bus.digit_sel  = r_digit_sel;
   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_data_valid;
endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry with DEBOUNCE_CYCLES = 4 (event latency 8 edges).
module tb_hex_entry;
   logic       clk;
   logic       rst_n;
   logic [3:0] btn;   // 0 inc, 1 dec, 2 sel, 3 ok
   int         n_cmp;
   int         n_err;
   int         dv_cnt;
   int         dv_base;

   hex_entry_if bus ();

   assign bus.btn_inc = btn[0];
   assign bus.btn_dec = btn[1];
   assign bus.btn_sel = btn[2];
   assign bus.btn_ok  = btn[3];

   hex_entry #(.DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles with data_valid high, sampled on the falling edge.
   initial dv_cnt = 0;
   always @(negedge clk) if (bus.data_valid) dv_cnt = dv_cnt + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      @(negedge clk);
      btn = m;
      repeat (hold) @(negedge clk);
      btn = 4'b0000;
      repeat (12) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] v);
      @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_data = v;
      @(negedge clk);
      bus.load_en   = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      btn = 4'b0000;
      bus.load_en = 1'b0;
      bus.load_data = 8'h00;
      rst_n = 1'b0;
      #12;
      chk("rst_edit", 16'(bus.edit_value), 16'h00);
      chk("rst_dout", 16'(bus.data_out), 16'h00);
      chk("rst_dv",   16'(bus.data_valid), 16'h0);
      chk("rst_dsel", 16'(bus.digit_sel), 16'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Held inc: change lands exactly on the 8th sampling edge, then no repeat.
      @(negedge clk);
      btn = 4'b0001;
      repeat (7) @(posedge clk);
      #1 chk("lat_e7", 16'(bus.edit_value), 16'h00);
      @(posedge clk);
      #1 chk("lat_e8", 16'(bus.edit_value), 16'h10);
      repeat (30) @(negedge clk);
      chk("no_rpt", 16'(bus.edit_value), 16'h10);
      btn = 4'b0000;
      repeat (12) @(negedge clk);

      // Lower nibble wraps both ways without touching the upper nibble.
      load(8'h0F);
      chk("load0F", 16'(bus.edit_value), 16'h0F);
      press(4'b0100, 8);
      chk("sel_lo", 16'(bus.digit_sel), 16'h0);
      press(4'b0001, 8);
      chk("inc_wrap", 16'(bus.edit_value), 16'h00);
      press(4'b0010, 8);
      chk("dec_wrap", 16'(bus.edit_value), 16'h0F);
      press(4'b0100, 8);
      chk("sel_hi", 16'(bus.digit_sel), 16'h1);

      // Upper nibble wrap F -> 0.
      load(8'hF3);
      press(4'b0001, 8);
      chk("hi_wrap", 16'(bus.edit_value), 16'h03);

      // Commit.
      load(8'hA5);
      press(4'b0100, 8);      // move to lower nibble; commit must return to upper
      dv_base = dv_cnt;
      press(4'b1000, 8);
      chk("cm_dout", 16'(bus.data_out), 16'hA5);
      chk("cm_dv1",  16'(dv_cnt - dv_base), 16'd1);
      chk("cm_dsel", 16'(bus.digit_sel), 16'h1);
      chk("cm_edit", 16'(bus.edit_value), 16'hA5);

      // Short glitches never debounce.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         btn = 4'b0001;
         repeat (3) @(negedge clk);
         btn = 4'b0000;
         repeat (3) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      chk("glitch", 16'(bus.edit_value), 16'hA5);

      // Simultaneous inc and dec cancel.
      press(4'b0011, 8);
      chk("incdec", 16'(bus.edit_value), 16'hA5);

      // load_en coincident with the ok event wins; no commit.
      dv_base = dv_cnt;
      @(negedge clk);
      btn = 4'b1000;
      repeat (7) @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_data = 8'h3C;
      @(negedge clk);
      bus.load_en   = 1'b0;
      repeat (3) @(negedge clk);
      btn = 4'b0000;
      repeat (12) @(negedge clk);
      chk("ldok_edit", 16'(bus.edit_value), 16'h3C);
      chk("ldok_dv",   16'(dv_cnt - dv_base), 16'd0);
      chk("ldok_dout", 16'(bus.data_out), 16'hA5);

      // Reset mid-COMMIT clears immediately, nothing pulses afterwards.
      @(negedge clk);
      btn = 4'b1000;
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1 chk("cm_enter", 16'(bus.data_valid), 16'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_edit", 16'(bus.edit_value), 16'h00);
      chk("ar_dout", 16'(bus.data_out), 16'h00);
      chk("ar_dv",   16'(bus.data_valid), 16'h0);
      chk("ar_dsel", 16'(bus.digit_sel), 16'h1);
      btn = 4'b0000;
      dv_base = dv_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("ar_nodv", 16'(dv_cnt - dv_base), 16'd0);
      chk("ar_dout2", 16'(bus.data_out), 16'h00);

      // Button held through reset release counts as a fresh press.
      @(negedge clk);
      rst_n = 1'b0;
      btn = 4'b0001;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #1 chk("rr_e7", 16'(bus.edit_value), 16'h00);
      @(posedge clk);
      #1 chk("rr_e8", 16'(bus.edit_value), 16'h10);
      btn = 4'b0000;
      repeat (12) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/hex_entry.md
HEX_ENTRY -- requirements
Module: hex_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive cycles a synchronized button must disagree with its debounced level before that level flips (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port btn_inc  input  1  raw active-high button, increment selected nibble; asynchronous to clk.
REQ-005 SHALL have port btn_dec  input  1  raw active-high button, decrement selected nibble; asynchronous.
REQ-006 SHALL have port btn_sel  input  1  raw active-high button, toggle selected nibble; asynchronous.
REQ-007 SHALL have port btn_ok  input  1  raw active-high button, commit edit value; asynchronous.
REQ-008 SHALL have port load_en  input  1  synchronous preset strobe.
REQ-009 SHALL have port load_data  input  8  preset value for edit buffer.
REQ-010 SHALL have port edit_value  output  8  current edit buffer, registered, for the two-digit hex display.
REQ-011 SHALL have port digit_sel  output  1  selected nibble: 1 = upper [7:4], 0 = lower [3:0].
REQ-012 SHALL have port data_out  output  8  last committed value, registered.
REQ-013 SHALL have port data_valid  output  1  single-cycle pulse marking a commit.

Function
REQ-014 Each button SHALL pass through its own 2-flop synchronizer before any other use.
REQ-015 Each button SHALL have an independent debouncer: a counter increments while synchronized input differs from debounced level, clears when they agree, and the level flips when DEBOUNCE_CYCLES consecutive disagreeing cycles are reached.
REQ-016 Each debouncer SHALL produce a registered one-cycle event pulse the cycle after its debounced level rises; falling edges produce no event.
REQ-017 A raw press held stable SHALL change edit_value/digit_sel/data_out exactly DEBOUNCE_CYCLES+4 rising edges after the first edge sampling it high.
REQ-018 A press held indefinitely SHALL produce exactly one event (no auto-repeat); glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce none.
REQ-019 FSM states: EDIT_HI (digit_sel=1), EDIT_LO (digit_sel=0), COMMIT.
REQ-020 EDIT_HI --sel event--> EDIT_LO; EDIT_LO --sel event--> EDIT_HI.
REQ-021 EDIT_HI or EDIT_LO --ok event--> COMMIT; in COMMIT data_out <= edit_value and data_valid = 1 for that one cycle.
REQ-022 COMMIT SHALL return unconditionally to EDIT_HI next cycle; any event arriving while in COMMIT SHALL be dropped.
REQ-023 Inc event SHALL add 1 to the selected nibble modulo 16 (F -> 0); dec event SHALL subtract 1 modulo 16 (0 -> F); the other nibble SHALL never change (no carry/borrow).
REQ-024 Inc and dec events in the same cycle SHALL cancel (no change).
REQ-025 Priority per cycle: load_en > ok > sel > inc/dec; lower-priority events coinciding with a higher one SHALL be discarded, not deferred.
REQ-026 load_en SHALL set edit_value <= load_data and state <= EDIT_HI on the next edge, in any state including COMMIT (commit aborted, no data_valid).
REQ-027 edit_value SHALL be unchanged by commit; data_out SHALL change only in COMMIT.

Reset
REQ-028 On rst_n low, immediately and regardless of clk: edit_value = 0x00, data_out = 0x00, data_valid = 0, state EDIT_HI (digit_sel = 1), all synchronizer flops, debounced levels, counters and event pulses = 0.
REQ-029 A button held through reset release SHALL be treated as a new press and produce one event after the normal debounce latency.
REQ-030 Reset asserted mid-debounce or in COMMIT SHALL discard that event/commit; no data_valid pulse after release.

Verification
REQ-031 DEBOUNCE_CYCLES=4; reset; hold btn_inc high -> edit_value 0x00 -> 0x10 exactly 8 edges after first sample, no further change while held.
REQ-032 load 0x0F, press sel, press inc -> edit_value 0x00 (lower nibble wrap, upper unchanged); press dec -> 0x0F.
REQ-033 load 0xA5, press ok -> data_out 0xA5, data_valid high exactly one cycle, digit_sel 1 afterwards, edit_value still 0xA5.
REQ-034 btn_inc pulses of 3 cycles repeatedly with DEBOUNCE_CYCLES=4 -> no event, edit_value unchanged.
REQ-035 inc and dec pressed simultaneously -> no change; load_en in same cycle as ok event -> edit_value = load_data, data_valid stays 0.
REQ-036 Assert rst_n low between clock edges during COMMIT -> outputs zero immediately, no data_valid after release.
